// File: rtl/router_fsm_if.sv
// Bundles the router_fsm control-side signals between the input port, router_register, the FIFOs and the synchronizer.
// Optional macro: ROUTER_FSM_STATE_OUT_EN adds the state_dbg debug signal.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;
`ifdef ROUTER_FSM_STATE_OUT_EN
    logic [2:0] state_dbg;
`endif

    // Environment side: drives packet/status inputs, observes the strobes.
    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  rst_int_reg, write_enb_reg, busy
`ifdef ROUTER_FSM_STATE_OUT_EN
        , input state_dbg
`endif
    );

    // FSM side.
    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output rst_int_reg, write_enb_reg, busy
`ifdef ROUTER_FSM_STATE_OUT_EN
        , output state_dbg
`endif
    );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: header decode, packet load sequencing, FIFO write enable and busy.
// Optional macro: ROUTER_FSM_STATE_OUT_EN exposes the current state code on state_dbg.
module router_fsm (
    input  logic          clock,
    input  logic          resetn,
    router_fsm_if.slave   bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    // Bit order: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] OUT_RESET = 8'b1000_0000;

    state_e     state_r;
    state_e     next_state_s;
    logic [1:0] addr_r;
    logic [7:0] out_r;
    logic       hdr_empty_s;
    logic       sel_empty_s;
    logic       sel_soft_rst_s;
    logic       capture_s;

    function automatic logic pick_port(input logic [1:0] sel, input logic p0,
                                       input logic p1, input logic p2);
        logic v;
        v = 1'b0;
        case (sel)
            2'd0:    v = p0;
            2'd1:    v = p1;
            2'd2:    v = p2;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // Strobes are a pure function of state; computing them from the next state
    // lets them be registered alongside it with no extra cycle of latency.
    function automatic logic [7:0] decode_outputs(input state_e st);
        logic [7:0] v;
        v = OUT_RESET;
        case (st)
            DECODE_ADDRESS:     v = 8'b1000_0000;
            LOAD_FIRST_DATA:    v = 8'b0100_0011;
            LOAD_DATA:          v = 8'b0010_0010;
            WAIT_TILL_EMPTY:    v = 8'b0000_0001;
            FIFO_FULL_STATE:    v = 8'b0000_1001;
            LOAD_AFTER_FULL:    v = 8'b0001_0011;
            LOAD_PARITY:        v = 8'b0000_0011;
            CHECK_PARITY_ERROR: v = 8'b0000_0101;
            default:            v = OUT_RESET;
        endcase
        return v;
    endfunction

    // Port status selection: header decode uses the live address, later states the latched one.
    always_comb begin
        hdr_empty_s    = pick_port(bus.data_in, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
        sel_empty_s    = pick_port(addr_r, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
        sel_soft_rst_s = pick_port(addr_r, bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2);
        capture_s      = (state_r == DECODE_ADDRESS) && bus.pkt_valid && (bus.data_in != 2'd3);
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        if ((state_r != DECODE_ADDRESS) && sel_soft_rst_s) begin
            next_state_s = DECODE_ADDRESS;
        end else begin
            case (state_r)
                DECODE_ADDRESS: begin
                    if (capture_s) begin
                        next_state_s = hdr_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    next_state_s = sel_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: begin
                    next_state_s = LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (bus.fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else if (!bus.pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    next_state_s = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done) begin
                        next_state_s = DECODE_ADDRESS;
                    end else if (bus.low_pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                LOAD_PARITY: begin
                    next_state_s = CHECK_PARITY_ERROR;
                end
                CHECK_PARITY_ERROR: begin
                    next_state_s = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: begin
                    next_state_s = DECODE_ADDRESS;
                end
            endcase
        end
    end

    // State register and registered strobe outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= DECODE_ADDRESS;
            out_r   <= OUT_RESET;
        end else begin
            state_r <= next_state_s;
            out_r   <= decode_outputs(next_state_s);
        end
    end

    // Header address latch.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_r <= 2'd0;
        end else if (capture_s) begin
            addr_r <= bus.data_in;
        end else begin
            addr_r <= addr_r;
        end
    end

    assign bus.detect_add    = out_r[7];
    assign bus.lfd_state     = out_r[6];
    assign bus.ld_state      = out_r[5];
    assign bus.laf_state     = out_r[4];
    assign bus.full_state    = out_r[3];
    assign bus.rst_int_reg   = out_r[2];
    assign bus.write_enb_reg = out_r[1];
    assign bus.busy          = out_r[0];
`ifdef ROUTER_FSM_STATE_OUT_EN
    assign bus.state_dbg     = state_r;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: expected state codes are queued as each cycle is driven and compared after the edge.
module tb_router_fsm;

    localparam logic [2:0] S_DEC  = 3'd0;
    localparam logic [2:0] S_LFD  = 3'd1;
    localparam logic [2:0] S_LD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_FULL = 3'd4;
    localparam logic [2:0] S_LAF  = 3'd5;
    localparam logic [2:0] S_PAR  = 3'd6;
    localparam logic [2:0] S_CHK  = 3'd7;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;
    logic [2:0] exp_q[$];

    router_fsm_if bus();

    router_fsm dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy} for a state.
    function automatic logic [7:0] exp_out(input logic [2:0] st);
        logic [7:0] v;
        case (st)
            S_DEC:   v = 8'b1000_0000;
            S_LFD:   v = 8'b0100_0011;
            S_LD:    v = 8'b0010_0010;
            S_WAIT:  v = 8'b0000_0001;
            S_FULL:  v = 8'b0000_1001;
            S_LAF:   v = 8'b0001_0011;
            S_PAR:   v = 8'b0000_0011;
            default: v = 8'b0000_0101;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag);
        logic [2:0] st;
        logic [7:0] obs;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            st  = exp_q.pop_front();
            obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                   bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
            checks++;
            assert (obs === exp_out(st)) else begin
                errors++;
                $error("FAIL %s outputs observed %b expected %b (state %0d)", tag, obs, exp_out(st), st);
            end
`ifdef ROUTER_FSM_STATE_OUT_EN
            checks++;
            assert (bus.state_dbg === st) else begin
                errors++;
                $error("FAIL %s state_dbg observed %0d expected %0d", tag, bus.state_dbg, st);
            end
`endif
        end
    endtask

    // One clock: queue the expected state, take the edge, compare 1 time unit later.
    task automatic cyc(input logic [2:0] st, input string tag);
        exp_q.push_back(st);
        @(posedge clock);
        #1;
        chk(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.pkt_valid = 1'b0;     bus.data_in = 2'd0;      bus.fifo_full = 1'b0;
        bus.fifo_empty_0 = 1'b1;  bus.fifo_empty_1 = 1'b1; bus.fifo_empty_2 = 1'b1;
        bus.soft_reset_0 = 1'b0;  bus.soft_reset_1 = 1'b0; bus.soft_reset_2 = 1'b0;
        bus.parity_done = 1'b0;   bus.low_pkt_valid = 1'b0;
        #12;
        exp_q.push_back(S_DEC);
        chk("reset");
        resetn = 1'b1;
        @(posedge clock); #1;

        // Normal packet to port 2: 0,1,2x5,6,7,0
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b1;
        cyc(S_LFD, "hdr_to_lfd");
        for (int i = 0; i < 5; i++) cyc(S_LD, "payload");
        bus.pkt_valid = 1'b0;
        cyc(S_PAR, "load_parity");
        cyc(S_CHK, "check_parity");
        cyc(S_DEC, "back_to_decode");

        // Busy target port 1: wait four cycles then load
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1; bus.fifo_empty_1 = 1'b0;
        for (int i = 0; i < 4; i++) cyc(S_WAIT, "wait_empty");
        bus.fifo_empty_1 = 1'b1;
        cyc(S_LFD, "wait_to_lfd");
        cyc(S_LD, "lfd_to_ld");

        // FIFO full for 3 cycles, resume to LOAD_DATA
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) cyc(S_FULL, "fifo_full");
        bus.fifo_full = 1'b0;
        cyc(S_LAF, "after_full");
        cyc(S_LD, "laf_to_ld");

        // full and pkt_valid fall together: full wins, parity via low_pkt_valid
        bus.fifo_full = 1'b1; bus.pkt_valid = 1'b0;
        cyc(S_FULL, "full_priority");
        bus.fifo_full = 1'b0;
        cyc(S_LAF, "after_full2");
        bus.low_pkt_valid = 1'b1;
        cyc(S_PAR, "laf_low_pkt");
        bus.low_pkt_valid = 1'b0;
        cyc(S_CHK, "check_parity2");
        cyc(S_DEC, "decode2");

        // Port 0 packet ending through parity_done
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        cyc(S_LFD, "p0_lfd");
        cyc(S_LD, "p0_ld");
        bus.fifo_full = 1'b1;
        cyc(S_FULL, "p0_full");
        bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
        cyc(S_LAF, "p0_laf");
        bus.parity_done = 1'b1;
        cyc(S_DEC, "laf_parity_done");
        bus.parity_done = 1'b0;

        // CHECK_PARITY_ERROR with fifo_full goes to FIFO_FULL_STATE
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        cyc(S_LFD, "p1_lfd");
        bus.pkt_valid = 1'b0;
        cyc(S_LD, "p1_ld");
        cyc(S_PAR, "p1_par");
        bus.fifo_full = 1'b1;
        cyc(S_CHK, "p1_chk");
        cyc(S_FULL, "chk_to_full");
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        cyc(S_LAF, "p1_laf");
        cyc(S_DEC, "p1_done");
        bus.parity_done = 1'b0;

        // Invalid address stays in decode
        bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
        cyc(S_DEC, "invalid_addr");
        cyc(S_DEC, "invalid_addr2");
        bus.pkt_valid = 1'b0; bus.data_in = 2'd0;
        cyc(S_DEC, "idle");

        // Soft reset: non-selected ignored, selected flushes, ignored in decode
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        cyc(S_LFD, "sr_lfd");
        cyc(S_LD, "sr_ld");
        bus.soft_reset_2 = 1'b1;
        cyc(S_LD, "soft_reset_other");
        bus.soft_reset_2 = 1'b0; bus.soft_reset_0 = 1'b1;
        cyc(S_DEC, "soft_reset_sel");
        cyc(S_LFD, "soft_reset_in_decode");
        cyc(S_DEC, "soft_reset_lfd");
        bus.soft_reset_0 = 1'b0;

        // Asynchronous reset mid-packet
        cyc(S_LFD, "ar_lfd");
        cyc(S_LD, "ar_ld");
        #2;
        resetn = 1'b0;
        #1;
        exp_q.push_back(S_DEC);
        chk("async_reset");
        bus.pkt_valid = 1'b0;
        #3;
        resetn = 1'b1;
        cyc(S_DEC, "post_reset");
        cyc(S_DEC, "post_reset2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
# router_fsm

Control state machine for the 1x3 router. It decodes the header address, sequences the per-packet loading of `router_register` (header, payload, parity, FIFO-full hold and parity check), and drives the FIFO write enable and the source-side `busy` flow control. It sits between the input port, `router_register`, the three output FIFOs and the synchronizer that supplies per-port empty and soft-reset status.

## Interface
- No parameters.
- clock  input  1  system clock; all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- pkt_valid  input  1  source asserts for the duration of a packet (header and payload), deasserts with the parity byte
- data_in  input  2  header address bits; 0/1/2 select an output port, 3 is invalid
- fifo_full  input  1  the FIFO selected by the synchronizer is full
- fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  output FIFO k is empty
- soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  timeout flush for output port k
- parity_done  input  1  from `router_register`: parity byte has been captured
- low_pkt_valid  input  1  from `router_register`: pkt_valid fell while the FIFO was full
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  state strobes to `router_register`
- write_enb_reg  output  1  FIFO write enable
- busy  output  1  source must hold data_in stable while high
- state_dbg  output  3  current state code; present only with ROUTER_FSM_STATE_OUT_EN

## Operation
- State codes: DECODE_ADDRESS=0, LOAD_FIRST_DATA=1, LOAD_DATA=2, WAIT_TILL_EMPTY=3, FIFO_FULL_STATE=4, LOAD_AFTER_FULL=5, LOAD_PARITY=6, CHECK_PARITY_ERROR=7.
- Address latch: a 2-bit register captures data_in in DECODE_ADDRESS when pkt_valid=1 and data_in!=3. The latched value selects fifo_empty_k and soft_reset_k until the next capture.
- Transitions:
  - DECODE_ADDRESS: pkt_valid and data_in=k (k<3)
    - fifo_empty_k=1 -> LOAD_FIRST_DATA
    - fifo_empty_k=0 -> WAIT_TILL_EMPTY
    - data_in=3 or pkt_valid=0 -> stay
  - WAIT_TILL_EMPTY: selected fifo_empty=1 -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE (takes priority); else pkt_valid=0 -> LOAD_PARITY; else stay.
  - FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS
    - low_pkt_valid -> LOAD_PARITY
    - otherwise -> LOAD_DATA
  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- Soft reset: soft_reset_k=1, where k is the latched address, forces DECODE_ADDRESS on the next edge from any state other than DECODE_ADDRESS. It overrides all other transitions. Soft resets for non-selected ports are ignored.
- Outputs are Moore-decoded from state only:
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_FIRST_DATA | LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY
  - busy = any state except DECODE_ADDRESS and LOAD_DATA

## Timing
- Reset (asynchronous, immediate):
  - state = DECODE_ADDRESS, address latch = 0
  - detect_add=1, all other strobes 0, write_enb_reg=0, busy=0, state_dbg=0
- Reset asserted mid-packet abandons the packet. After release, the FSM waits in DECODE_ADDRESS for a new header.
- Header to first write: pkt_valid with a valid address and an empty target FIFO at edge N puts the FSM in LOAD_FIRST_DATA after N, with write_enb_reg=1 and busy=1. LOAD_DATA follows after edge N+1.
- Payload: one byte per cycle in LOAD_DATA. pkt_valid sampled 0 at edge M gives LOAD_PARITY after M, CHECK_PARITY_ERROR after M+1, and DECODE_ADDRESS after M+2 (if fifo_full=0).
- fifo_full and pkt_valid falling in the same cycle in LOAD_DATA: FIFO_FULL_STATE is taken. The pending parity is resolved through LOAD_AFTER_FULL via low_pkt_valid.
- Outputs are registered-state decodes with no combinational path from inputs to outputs.

## Configuration
- ROUTER_FSM_STATE_OUT_EN defined: port state_dbg exists and equals the current 3-bit state code, with reset value 0.
- Not defined: state_dbg port is absent. State behaviour is otherwise identical.

## Test plan
- Reset mid-packet: assert resetn=0 asynchronously while in LOAD_DATA -> detect_add=1 immediately, busy=0, write_enb_reg=0. After release, stays in DECODE with pkt_valid=0.
- Normal packet: header data_in=2, fifo_empty_2=1, 5 payload cycles, then pkt_valid=0 -> state sequence 0,1,2,2,2,2,2,6,7,0. write_enb_reg high for 7 cycles. rst_int_reg high for 1 cycle.
- Busy target: data_in=1, fifo_empty_1=0 for 4 cycles -> WAIT_TILL_EMPTY with busy=1 for 4 cycles. The cycle after fifo_empty_1=1 is LOAD_FIRST_DATA.
- FIFO full: fifo_full=1 for 3 cycles in LOAD_DATA -> full_state=1 and write_enb_reg=0 for 3 cycles, then LOAD_AFTER_FULL for 1 cycle.
  - low_pkt_valid=1 -> LOAD_PARITY
  - parity_done=1 -> DECODE
- Invalid address and soft reset:
  - data_in=3 with pkt_valid=1 -> remains in DECODE.
  - Latched addr 0, soft_reset_0=1 in LOAD_DATA -> DECODE next cycle.
  - soft_reset_2=1 with latched addr 0 -> no effect.
